// File: rtl/branch_trace_sequencer.sv
// rtl/branch_trace_sequencer.sv - SPI trace deserializer driving branch predictor request/update handshakes
//
// Receives SPI mode-0 frames (ADDR_W/8 address bytes MSB first, then one
// direction byte whose bit 0 is "taken"). Each accepted frame is turned into
// a predictor request, a wait for the prediction (with timeout), a training
// update carrying the ground truth, and a completion pulse.
//
// Optional feature macro: BRANCH_SEQ_STATS_EN (saturating branch/miss counters).
//
// Ports:
//   clk, rst                  system clock, asynchronous active-high reset
//   spi_cs, spi_mosi, spi_clk raw SPI inputs, asynchronous to clk
//   pred_req, pred_addr       one-cycle request and branch address to predictor
//   pred_valid, pred_taken    predictor response
//   upd_valid, upd_taken      one-cycle training update with actual direction
//   direction_ground_truth    actual direction of the last processed record
//   data_input_done           one-cycle pulse when a record completes
//   mispredict                one-cycle pulse when prediction differs from truth
//   overrun                   sticky: a frame arrived while busy and was dropped
//   busy                      sequencer not idle
//   branch_count, miss_count  statistics (zero when stats are disabled)

module branch_trace_sequencer #(
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 16,
    parameter int PRED_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    input  logic              spi_clk,
    output logic              pred_req,
    output logic [ADDR_W-1:0] pred_addr,
    input  logic              pred_valid,
    input  logic              pred_taken,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic              direction_ground_truth,
    output logic              data_input_done,
    output logic              mispredict,
    output logic              overrun,
    output logic              busy,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int NB = ADDR_W / 8;
    localparam int FW = ADDR_W + 8;
    localparam int TW = (PRED_TIMEOUT < 2) ? 1 : $clog2(PRED_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state, next_state;

    // SPI synchronizers; sclk_d is the extra stage used for rising-edge detection
    logic cs_meta, cs_s, mosi_meta, mosi_s, sclk_meta, sclk_s, sclk_d;
    logic [FW-1:0] sr;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic          frame_done;
    logic          sclk_rise;

    // Only bit 0 of the direction byte carries information
    logic unused_dir_bits;
    assign unused_dir_bits = ^sr[7:1];

    assign sclk_rise = sclk_s & ~sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta    <= 1'b1;
            cs_s       <= 1'b1;
            mosi_meta  <= 1'b0;
            mosi_s     <= 1'b0;
            sclk_meta  <= 1'b0;
            sclk_s     <= 1'b0;
            sclk_d     <= 1'b0;
            sr         <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            cs_meta    <= spi_cs;
            cs_s       <= cs_meta;
            mosi_meta  <= spi_mosi;
            mosi_s     <= mosi_meta;
            sclk_meta  <= spi_clk;
            sclk_s     <= sclk_meta;
            sclk_d     <= sclk_s;
            frame_done <= 1'b0;
            if (cs_s) begin
                // Deselect discards any partial frame
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sclk_rise) begin
                sr      <= {sr[FW-2:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt == 2'(NB)) begin
                        byte_cnt   <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
            end
        end
    end

    // Sequencer datapath
    logic          dir_r, pred_r, dgt_r;
    logic [TW-1:0] wait_cnt;
    logic          wait_expired;

    assign wait_expired = (wait_cnt == TW'(PRED_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_addr <= '0;
            dir_r     <= 1'b0;
            pred_r    <= 1'b0;
            dgt_r     <= 1'b0;
            wait_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            // The shift register holds the finished frame for several cycles
            // after frame_done, since the next spi_clk rise is >= 6 clk away
            if (frame_done) begin
                if (state == S_IDLE) begin
                    pred_addr <= sr[FW-1:8];
                    dir_r     <= sr[0];
                end else begin
                    overrun <= 1'b1;
                end
            end
            case (state)
                S_REQ:    wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (pred_valid) begin
                        pred_r <= pred_taken;
                    end else if (wait_expired) begin
                        pred_r <= 1'b0;
                    end
                end
                S_UPDATE: dgt_r <= dir_r;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state             = state;
        pred_req               = 1'b0;
        upd_valid              = 1'b0;
        upd_taken              = 1'b0;
        mispredict             = 1'b0;
        data_input_done        = 1'b0;
        busy                   = (state != S_IDLE);
        // Truth becomes visible in the UPDATE cycle itself, then is held by dgt_r
        direction_ground_truth = dgt_r;
        case (state)
            S_IDLE: begin
                if (frame_done) next_state = S_REQ;
            end
            S_REQ: begin
                pred_req   = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (pred_valid || wait_expired) next_state = S_UPDATE;
            end
            S_UPDATE: begin
                upd_valid              = 1'b1;
                upd_taken              = dir_r;
                mispredict             = (pred_r != dir_r);
                direction_ground_truth = dir_r;
                next_state             = S_DONE;
            end
            S_DONE: begin
                data_input_done = 1'b1;
                next_state      = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

`ifdef BRANCH_SEQ_STATS_EN
    logic [CNT_W-1:0] branch_cnt_r, miss_cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r <= '0;
            miss_cnt_r   <= '0;
        end else begin
            if (upd_valid && (branch_cnt_r != '1)) branch_cnt_r <= branch_cnt_r + 1'b1;
            if (mispredict && (miss_cnt_r != '1)) miss_cnt_r <= miss_cnt_r + 1'b1;
        end
    end

    assign branch_count = branch_cnt_r;
    assign miss_count   = miss_cnt_r;
`else
    assign branch_count = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// tb/tb_branch_trace_sequencer.sv - directed self-checking bench for branch_trace_sequencer

module tb_branch_trace_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_clk = 1'b0;
    logic        pred_valid = 1'b0;
    logic        pred_taken = 1'b0;

    logic        pred_req, upd_valid, upd_taken, dgt, done, misp, overrun, busy;
    logic [15:0] pred_addr, branch_count, miss_count;

    logic        s_pred_req, s_upd_valid, s_upd_taken, s_dgt, s_done, s_misp, s_overrun, s_busy;
    logic [15:0] s_pred_addr, s_branch_count, s_miss_count;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int upd_cnt = 0;
    int s_done_cnt = 0;

    always #5 clk = ~clk;

    branch_trace_sequencer #(.ADDR_W(16), .CNT_W(16), .PRED_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_clk(spi_clk),
        .pred_req(pred_req), .pred_addr(pred_addr),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_taken(upd_taken),
        .direction_ground_truth(dgt), .data_input_done(done),
        .mispredict(misp), .overrun(overrun), .busy(busy),
        .branch_count(branch_count), .miss_count(miss_count)
    );

    // Long-timeout instance with a silent predictor, used to hold WAIT long
    // enough for a back-to-back frame to arrive and be dropped.
    branch_trace_sequencer #(.ADDR_W(16), .CNT_W(16), .PRED_TIMEOUT(400)) u_slow (
        .clk(clk), .rst(rst),
        .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_clk(spi_clk),
        .pred_req(s_pred_req), .pred_addr(s_pred_addr),
        .pred_valid(1'b0), .pred_taken(1'b0),
        .upd_valid(s_upd_valid), .upd_taken(s_upd_taken),
        .direction_ground_truth(s_dgt), .data_input_done(s_done),
        .mispredict(s_misp), .overrun(s_overrun), .busy(s_busy),
        .branch_count(s_branch_count), .miss_count(s_miss_count)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (upd_valid === 1'b1) upd_cnt++;
        if (s_done === 1'b1) s_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        spi_clk  = 1'b0;
        spi_mosi = b;
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic spi_begin();
        spi_cs  = 1'b0;
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_end();
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Leaves spi_clk high and cs low right after the last rising edge
    task automatic send_frame(input logic [15:0] a, input logic [7:0] d);
        spi_begin();
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
        spi_byte(d);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (pred_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, pred_req}, 32'd1);
    endtask

    int n;
    int snap_done, snap_upd, snap_sdone;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst pred_req", {31'd0, pred_req}, 0);
        check("rst pred_addr", {16'd0, pred_addr}, 0);
        check("rst upd_valid", {31'd0, upd_valid}, 0);
        check("rst dgt", {31'd0, dgt}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst overrun", {31'd0, overrun}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst branch_count", {16'd0, branch_count}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Record 0x1234 taken, predictor answers taken in first WAIT cycle
        send_frame(16'h1234, 8'h01);
        wait_req("t1 req");
        check("t1 pred_addr", {16'd0, pred_addr}, 32'h1234);
        check("t1 busy", {31'd0, busy}, 1);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_taken = 1'b1;
        @(negedge clk);
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        check("t1 upd_valid", {31'd0, upd_valid}, 1);
        check("t1 upd_taken", {31'd0, upd_taken}, 1);
        check("t1 mispredict", {31'd0, misp}, 0);
        check("t1 dgt", {31'd0, dgt}, 1);
        @(negedge clk);
        check("t1 done", {31'd0, done}, 1);
        check("t1 upd_valid low", {31'd0, upd_valid}, 0);
`ifdef BRANCH_SEQ_STATS_EN
        check("t1 branch_count", {16'd0, branch_count}, 1);
`else
        check("t1 branch_count", {16'd0, branch_count}, 0);
`endif
        check("t1 miss_count", {16'd0, miss_count}, 0);
        @(negedge clk);
        check("t1 done low", {31'd0, done}, 0);
        check("t1 idle", {31'd0, busy}, 0);
        check("t1 dgt held", {31'd0, dgt}, 1);
        spi_end();

        // Reset asserted mid-WAIT aborts the record
        send_frame(16'h5566, 8'h01);
        wait_req("rw req");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw busy", {31'd0, busy}, 0);
        check("rw pred_addr", {16'd0, pred_addr}, 0);
        check("rw dgt", {31'd0, dgt}, 0);
        check("rw upd_valid", {31'd0, upd_valid}, 0);
        check("rw pred_req", {31'd0, pred_req}, 0);
        check("rw branch_count", {16'd0, branch_count}, 0);
        snap_done = done_cnt;
        snap_upd  = upd_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        spi_end();
        repeat (30) @(negedge clk);
        check("rw no done", done_cnt, snap_done);
        check("rw no upd", upd_cnt, snap_upd);

        // 0xBEEF not-taken, predictor says taken -> mispredict
        send_frame(16'hBEEF, 8'h00);
        wait_req("t2 req");
        check("t2 pred_addr", {16'd0, pred_addr}, 32'hBEEF);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_taken = 1'b1;
        @(negedge clk);
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        check("t2 upd_valid", {31'd0, upd_valid}, 1);
        check("t2 upd_taken", {31'd0, upd_taken}, 0);
        check("t2 mispredict", {31'd0, misp}, 1);
        check("t2 dgt", {31'd0, dgt}, 0);
        @(negedge clk);
        check("t2 done", {31'd0, done}, 1);
`ifdef BRANCH_SEQ_STATS_EN
        check("t2 branch_count", {16'd0, branch_count}, 1);
        check("t2 miss_count", {16'd0, miss_count}, 1);
`else
        check("t2 branch_count", {16'd0, branch_count}, 0);
        check("t2 miss_count", {16'd0, miss_count}, 0);
`endif
        spi_end();

        // Silent predictor: pred_valid pulsed only in the REQ cycle is ignored
        send_frame(16'h0F0F, 8'h01);
        wait_req("to req");
        pred_valid = 1'b1;
        pred_taken = 1'b1;
        @(negedge clk);
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        n = 1;
        while (upd_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to latency", n, 16);
        check("to mispredict", {31'd0, misp}, 1);
        check("to upd_taken", {31'd0, upd_taken}, 1);
        @(negedge clk);
        check("to done", {31'd0, done}, 1);
        spi_end();

        // Partial 12-bit frame discarded, then a full frame
        snap_done = done_cnt;
        spi_begin();
        spi_byte(8'hFF);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        spi_end();
        send_frame(16'hA55A, 8'h00);
        wait_req("pf req");
        check("pf pred_addr", {16'd0, pred_addr}, 32'hA55A);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_taken = 1'b0;
        @(negedge clk);
        pred_valid = 1'b0;
        check("pf upd_valid", {31'd0, upd_valid}, 1);
        check("pf mispredict", {31'd0, misp}, 0);
        spi_end();
        repeat (10) @(negedge clk);
        check("pf one record", done_cnt - snap_done, 1);

        // Back-to-back frames in one cs window; slow instance is still in WAIT
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        snap_done  = done_cnt;
        snap_sdone = s_done_cnt;
        send_frame(16'h0102, 8'h01);
        spi_byte(8'h03);
        spi_byte(8'h04);
        spi_byte(8'h01);
        repeat (2) @(negedge clk);
        check("ov slow overrun", {31'd0, s_overrun}, 1);
        check("ov main no overrun", {31'd0, overrun}, 0);
        spi_end();
        repeat (450) @(negedge clk);
        check("ov slow one record", s_done_cnt - snap_sdone, 1);
        check("ov slow overrun sticky", {31'd0, s_overrun}, 1);
        check("ov main two records", done_cnt - snap_done, 2);
        check("ov main pred_addr", {16'd0, pred_addr}, 32'h0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
